// File: rtl/demux_ctrl_pkg.sv
// demux_ctrl_pkg: shared types and constants for the demux dispatch controller
package demux_ctrl_pkg;
  localparam int NCH = 4;
  typedef logic [1:0] sel_t;
  typedef enum logic {MODE_RR, MODE_FIXED} mode_e;
  typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first enabled channel at or after ptr, searching upward mod 4
module rr_pick4
  import demux_ctrl_pkg::*;
(
  input  logic [3:0] en_mask,
  input  sel_t       ptr,
  output sel_t       pick,
  output logic       pick_ok
);
  logic [7:0] dbl;
  logic [3:0] rot;
  sel_t       off;
  // rotate so bit 0 is the channel at ptr, then take the lowest set bit
  always_comb begin
    dbl     = {en_mask, en_mask} >> ptr;
    rot     = dbl[3:0];
    off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick    = ptr + off;
    pick_ok = |en_mask;
  end
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: one-beat register dispatching a stream to one of four channels
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [1:0]    sel_cfg,
  input  logic [3:0]    en_mask,
  input  logic          cnt_clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);
  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  sel_t          sel_q, sel_d, ptr_q, ptr_d;
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  sel_t          rr_k, k;
  logic          rr_ok, pick_ok, out_xfer, acc;

  rr_pick4 u_pick (.en_mask(en_mask), .ptr(ptr_q), .pick(rr_k), .pick_ok(rr_ok));

  // destination choice, handshakes and next-state for every register
  always_comb begin
    k         = (mode == MODE_FIXED) ? sel_cfg : rr_k;
    pick_ok   = (mode == MODE_FIXED) ? en_mask[sel_cfg] : rr_ok;
    out_xfer  = (state_q == FULL) && out_ready[sel_q];
    in_ready  = pick_ok && ((state_q == EMPTY) || out_xfer);
    acc       = in_valid && in_ready;
    state_d   = acc ? FULL : out_xfer ? EMPTY : state_q;
    data_d    = acc ? in_data : data_q;
    sel_d     = acc ? k : sel_q;
    ptr_d     = (acc && mode == MODE_RR) ? sel_t'(k + 2'd1) : ptr_q;
    out_valid = (state_q == FULL) ? (4'b0001 << sel_q) : 4'b0000;
    for (int i = 0; i < NCH; i++)
      cnt_d[i] = cnt_clr ? '0 : (out_xfer && sel_q == sel_t'(i)) ? cnt_q[i] + CW'(1) : cnt_q[i];
  end

  // state, held beat, round-robin pointer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_data = data_q;
  assign sel      = sel_q;
  assign cnt0     = cnt_q[0];
  assign cnt1     = cnt_q[1];
  assign cnt2     = cnt_q[2];
  assign cnt3     = cnt_q[3];
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: table-driven directed checks of demux_dispatch_ctrl
module tb_demux_dispatch_ctrl;
  logic       clk = 0, rst_n = 0, mode = 0, cnt_clr = 0, in_valid = 0;
  logic [1:0] sel_cfg = 0;
  logic [3:0] en_mask = 4'hf, out_ready = 4'hf;
  logic [7:0] in_data = 0;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  int checks = 0, failures = 0;

  demux_dispatch_ctrl #(.DW(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_cfg(sel_cfg), .en_mask(en_mask),
    .cnt_clr(cnt_clr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sel(sel),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic md; logic [1:0] sc; logic [3:0] en; logic clr; logic iv; logic [7:0] d; logic [3:0] rdy;
    logic ir; logic [3:0] ov; logic [7:0] od; logic [1:0] s;
    logic cc; logic [7:0] c0, c1, c2, c3;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mv(logic md, logic [1:0] sc, logic [3:0] en, logic clr, logic iv,
                              logic [7:0] d, logic [3:0] rdy, logic ir, logic [3:0] ov,
                              logic [7:0] od, logic [1:0] s, logic cc,
                              logic [7:0] c0, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
    vec_t v;
    v.md = md; v.sc = sc; v.en = en; v.clr = clr; v.iv = iv; v.d = d; v.rdy = rdy;
    v.ir = ir; v.ov = ov; v.od = od; v.s = s; v.cc = cc;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_cnt(int idx, logic [7:0] c0, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
    chk("cnt0", idx, cnt0, c0);
    chk("cnt1", idx, cnt1, c1);
    chk("cnt2", idx, cnt2, c2);
    chk("cnt3", idx, cnt3, c3);
  endtask

  initial begin
    // round-robin over all four channels, one beat per cycle
    tv.push_back(mv(0,0,4'hf,0,1,8'h10,4'hf, 1,4'h0,8'h00,0, 1,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h11,4'hf, 1,4'h1,8'h10,0, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h12,4'hf, 1,4'h2,8'h11,1, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h13,4'hf, 1,4'h4,8'h12,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h14,4'hf, 1,4'h8,8'h13,3, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h15,4'hf, 1,4'h1,8'h14,0, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h16,4'hf, 1,4'h2,8'h15,1, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,1,8'h17,4'hf, 1,4'h4,8'h16,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,0,8'h00,4'hf, 1,4'h8,8'h17,3, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,0,0,8'h00,4'hf, 1,4'h0,8'h17,3, 1,2,2,2,2));
    // round-robin skipping disabled channels 0 and 2
    tv.push_back(mv(0,0,4'ha,0,1,8'h20,4'hf, 1,4'h0,8'h17,3, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'ha,0,1,8'h21,4'hf, 1,4'h2,8'h20,1, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'ha,0,1,8'h22,4'hf, 1,4'h8,8'h21,3, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'ha,0,1,8'h23,4'hf, 1,4'h2,8'h22,1, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'ha,0,0,8'h00,4'hf, 1,4'h8,8'h23,3, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'ha,1,0,8'h00,4'hf, 1,4'h0,8'h23,3, 1,2,4,2,4));
    // fixed channel 2 with a three-cycle consumer stall
    tv.push_back(mv(1,2,4'hf,0,1,8'h30,4'hb, 1,4'h0,8'h23,3, 1,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,1,8'h31,4'hb, 0,4'h4,8'h30,2, 0,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,1,8'h31,4'hb, 0,4'h4,8'h30,2, 0,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,1,8'h31,4'hb, 0,4'h4,8'h30,2, 0,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,1,8'h31,4'hf, 1,4'h4,8'h30,2, 0,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,1,8'h32,4'hf, 1,4'h4,8'h31,2, 0,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,0,8'h00,4'hf, 1,4'h4,8'h32,2, 0,0,0,0,0));
    tv.push_back(mv(1,2,4'hf,0,0,8'h00,4'hf, 1,4'h0,8'h32,2, 1,0,0,3,0));
    // nothing enabled stalls the input, then channel 0 opens
    tv.push_back(mv(0,0,4'h0,0,1,8'h40,4'hf, 0,4'h0,8'h32,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'h0,0,1,8'h40,4'hf, 0,4'h0,8'h32,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'h0,0,1,8'h40,4'hf, 0,4'h0,8'h32,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'h1,0,1,8'h40,4'hf, 1,4'h0,8'h32,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'h1,0,0,8'h00,4'hf, 1,4'h1,8'h40,0, 0,0,0,0,0));
    // held beat for channel 1 survives disabling channel 1
    tv.push_back(mv(0,0,4'hf,0,1,8'h50,4'h0, 1,4'h0,8'h40,0, 1,1,0,3,0));
    tv.push_back(mv(0,0,4'hd,0,0,8'h00,4'h0, 0,4'h2,8'h50,1, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hd,0,1,8'h51,4'h2, 1,4'h2,8'h50,1, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hd,0,0,8'h00,4'hf, 1,4'h4,8'h51,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hd,0,0,8'h00,4'hf, 1,4'h0,8'h51,2, 1,1,1,4,0));
    // counter clear wins over a coinciding delivery
    tv.push_back(mv(0,0,4'hf,0,1,8'h60,4'hf, 1,4'h0,8'h51,2, 0,0,0,0,0));
    tv.push_back(mv(0,0,4'hf,1,0,8'h00,4'hf, 1,4'h8,8'h60,3, 1,1,1,4,0));
    tv.push_back(mv(0,0,4'hf,0,0,8'h00,4'hf, 1,4'h0,8'h60,3, 1,0,0,0,0));

    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      mode = tv[i].md; sel_cfg = tv[i].sc; en_mask = tv[i].en; cnt_clr = tv[i].clr;
      in_valid = tv[i].iv; in_data = tv[i].d; out_ready = tv[i].rdy;
      #1;
      chk("in_ready", i, in_ready, tv[i].ir);
      chk("out_valid", i, out_valid, tv[i].ov);
      chk("out_data", i, out_data, tv[i].od);
      chk("sel", i, sel, tv[i].s);
      if (tv[i].cc) chk_cnt(i, tv[i].c0, tv[i].c1, tv[i].c2, tv[i].c3);
    end

    // reset asserted while holding a beat drops it and clears everything
    @(negedge clk);
    mode = 0; en_mask = 4'hf; cnt_clr = 0; out_ready = 4'hf; in_valid = 1; in_data = 8'h70;
    @(negedge clk);
    in_data = 8'h71;
    @(negedge clk);
    in_valid = 0; out_ready = 4'h0;
    #1;
    chk("pre_rst_out_valid", 100, out_valid, 4'h2);
    chk("pre_rst_cnt0", 100, cnt0, 8'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_out_valid", 101, out_valid, 4'h0);
    chk("rst_out_data", 101, out_data, 8'h00);
    chk("rst_sel", 101, sel, 2'd0);
    chk("rst_in_ready", 101, in_ready, 1'b1);
    chk_cnt(101, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 4'hf;
    @(negedge clk);
    #1;
    chk("post_rst_out_valid", 102, out_valid, 4'h0);
    in_valid = 1; in_data = 8'h80;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("post_rst_beat_valid", 103, out_valid, 4'h1);
    chk("post_rst_beat_data", 103, out_data, 8'h80);
    chk("post_rst_beat_sel", 103, sel, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
